// File: rtl/rtc_restore_sequencer_if.sv
// rtl/rtc_restore_sequencer_if.sv - footer capture and RTC replay word bus
interface rtc_restore_sequencer_if;
    logic [16:0] addr_in;
    logic [15:0] data_in;
    logic        wr_in;
    logic [16:0] addr_out;
    logic [15:0] data_out;
    logic        wr_out;

    modport master (
        output addr_in, data_in, wr_in,
        input  addr_out, data_out, wr_out
    );

    modport slave (
        input  addr_in, data_in, wr_in,
        output addr_out, data_out, wr_out
    );
endinterface

// File: rtl/rtc_restore_sequencer.sv
// rtl/rtc_restore_sequencer.sv - holds the RTC save footer and replays it after core reset release
module rtc_restore_sequencer #(
    parameter int REPLAY_GAP   = 1,
    parameter int FOOTER_WORDS = 5
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    external_reset_s,
    input  logic                    cart_download,
    input  logic                    RTC_valid,
    rtc_restore_sequencer_if.slave  bus,
    output logic                    loading_done,
    output logic                    rtc_restored
);
    localparam int             IDXW = 3;
    localparam logic [7:0]     FW8  = 8'(FOOTER_WORDS);
    localparam logic [IDXW-1:0] FWI = IDXW'(FOOTER_WORDS);
    localparam logic [2:0]     GAP  = 3'(REPLAY_GAP);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, REPLAY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [FOOTER_WORDS-1:0] mask_q, mask_d;
    logic [15:0]             buf_q [FOOTER_WORDS];
    logic [15:0]             buf_d [FOOTER_WORDS];
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [2:0]              gap_q, gap_d;
    logic                    wr_q, wr_d;
    logic [16:0]             addr_q, addr_d;
    logic [15:0]             data_q, data_d;
    logic                    done_q, done_d;
    logic                    restored_q, restored_d;

    logic                    capture_ok;
    logic [IDXW-1:0]         wr_idx;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^bus.addr_in[16:8];
    assign wr_idx         = bus.addr_in[IDXW-1:0];
    assign capture_ok     = (state_q == IDLE || state_q == LOAD || state_q == ARMED)
                          && bus.wr_in && (bus.addr_in[7:0] < FW8);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        wr_d       = 1'b0;
        addr_d     = '0;
        data_d     = '0;
        done_d     = done_q;
        restored_d = restored_q;

        // A new download wins over everything, including an in-flight capture.
        if (cart_download) begin
            state_d    = LOAD;
            mask_d     = '0;
            done_d     = 1'b0;
            restored_d = 1'b0;
        end else begin
            if (capture_ok) begin
                buf_d[wr_idx]  = bus.data_in;
                mask_d[wr_idx] = 1'b1;
            end

            case (state_q)
                IDLE: ;
                LOAD: state_d = ARMED;
                ARMED: begin
                    // Decision uses mask_d/buf_d so a word written on the release cycle counts.
                    if (!external_reset_s) begin
                        if ((&mask_d) && RTC_valid) begin
                            state_d = REPLAY;
                            wr_d    = 1'b1;
                            data_d  = buf_d[0];
                            idx_d   = IDXW'(1);
                            gap_d   = GAP;
                        end else begin
                            state_d    = DONE;
                            done_d     = 1'b1;
                            restored_d = 1'b0;
                        end
                    end
                end
                REPLAY: begin
                    if (idx_q == FWI) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        restored_d = 1'b1;
                    end else if (gap_q != 3'd0) begin
                        gap_d = gap_q - 3'd1;
                    end else begin
                        wr_d   = 1'b1;
                        addr_d = 17'(idx_q);
                        data_d = buf_q[idx_q];
                        idx_d  = idx_q + IDXW'(1);
                        gap_d  = GAP;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            restored_q <= 1'b0;
            for (int i = 0; i < FOOTER_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            restored_q <= restored_d;
            for (int i = 0; i < FOOTER_WORDS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign bus.wr_out   = wr_q;
    assign bus.addr_out = addr_q;
    assign bus.data_out = data_q;
    assign loading_done = done_q;
    assign rtc_restored = restored_q;
endmodule

// File: tb/tb_rtc_restore_sequencer.sv
// tb/tb_rtc_restore_sequencer.sv - directed bench with a slot-arithmetic reference model
module tb_rtc_restore_sequencer;
    localparam int G  = 1;
    localparam int FW = 5;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic external_reset_s = 1'b1;
    logic cart_download = 1'b0;
    logic RTC_valid = 1'b0;
    logic loading_done, rtc_restored;

    rtc_restore_sequencer_if bus ();

    rtc_restore_sequencer #(.REPLAY_GAP(G), .FOOTER_WORDS(FW)) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .external_reset_s (external_reset_s),
        .cart_download    (cart_download),
        .RTC_valid        (RTC_valid),
        .bus              (bus),
        .loading_done     (loading_done),
        .rtc_restored     (rtc_restored)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: footer as a sparse word table, replay as slot arithmetic on time since release.
    int          m_phase = 0;  // 0 idle, 1 download, 2 armed, 3 replaying, 4 done
    logic [15:0] m_buf [256];
    bit          m_have [256];
    int          rep_t = 0;
    logic        e_wr = 1'b0;
    logic [16:0] e_addr = '0;
    logic [15:0] e_data = '0;
    logic        e_done = 1'b0;
    logic        e_rest = 1'b0;

    function automatic bit footer_full();
        bit f = 1'b1;
        for (int i = 0; i < FW; i++) f &= m_have[i];
        return f;
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            for (int i = 0; i < 256; i++) m_have[i] = 1'b0;
            e_wr = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0; e_rest = 1'b0;
        end else begin
            e_wr = 1'b0; e_addr = '0; e_data = '0;
            if (cart_download) begin
                m_phase = 1;
                for (int i = 0; i < 256; i++) m_have[i] = 1'b0;
                e_done = 1'b0; e_rest = 1'b0;
            end else begin
                if (m_phase <= 2 && bus.wr_in && int'(bus.addr_in[7:0]) < FW) begin
                    m_buf[int'(bus.addr_in[7:0])]  = bus.data_in;
                    m_have[int'(bus.addr_in[7:0])] = 1'b1;
                end
                case (m_phase)
                    1: m_phase = 2;
                    2: if (!external_reset_s) begin
                        if (footer_full() && RTC_valid) begin
                            m_phase = 3; rep_t = 0;
                        end else begin
                            m_phase = 4; e_done = 1'b1; e_rest = 1'b0;
                        end
                    end
                    3: rep_t++;
                    default: ;
                endcase
                if (m_phase == 3) begin
                    if (rep_t == (FW - 1) * (G + 1) + 1) begin
                        m_phase = 4; e_done = 1'b1; e_rest = 1'b1;
                    end else if (rep_t % (G + 1) == 0) begin
                        e_wr   = 1'b1;
                        e_addr = 17'(rep_t / (G + 1));
                        e_data = m_buf[rep_t / (G + 1)];
                    end
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            chk("wr_out", 32'(bus.wr_out), 32'(e_wr));
            chk("data_out", 32'(bus.data_out), 32'(e_data));
            if (e_wr) chk("addr_out", 32'(bus.addr_out), 32'(e_addr));
            chk("loading_done", 32'(loading_done), 32'(e_done));
            chk("rtc_restored", 32'(rtc_restored), 32'(e_rest));
            if (bus.wr_out === 1'b1) pulse_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wr_word(input logic [16:0] a, input logic [15:0] d);
        bus.wr_in = 1'b1; bus.addr_in = a; bus.data_in = d;
        tick();
        bus.wr_in = 1'b0;
    endtask

    task automatic download();
        external_reset_s = 1'b1;
        cart_download = 1'b1;
        tick();
        cart_download = 1'b0;
        tick();
    endtask

    task automatic full_footer(input logic [15:0] base);
        for (int i = 0; i < FW; i++) wr_word(17'(i), 16'(base * (i + 1)));
    endtask

    initial begin
        bus.addr_in = '0; bus.data_in = '0; bus.wr_in = 1'b0;
        #2;
        chk("rst_wr", 32'(bus.wr_out), 0);
        chk("rst_addr", 32'(bus.addr_out), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_done", 32'(loading_done), 0);
        chk("rst_rest", 32'(rtc_restored), 0);
        tick();
        reset = 1'b0;
        cmp_en = 1'b1;
        tick(2);

        // Full footer, default pacing
        download();
        full_footer(16'h1111);
        RTC_valid = 1'b1;
        pulse_cnt = 0;
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            chk("t1_wr", 32'(bus.wr_out), 32'((k % 2 == 0) && (k <= 8)));
            if ((k % 2 == 0) && (k <= 8)) begin
                chk("t1_addr", 32'(bus.addr_out), 32'(k / 2));
                chk("t1_data", 32'(bus.data_out), 32'(16'h1111 * (k / 2 + 1)));
            end
            chk("t1_done", 32'(loading_done), 32'(k == 9));
            chk("t1_rest", 32'(rtc_restored), 32'(k == 9));
        end
        tick(3);
        chk("t1_pulses", 32'(pulse_cnt), 5);

        // Word 3 missing
        download();
        wr_word(17'd0, 16'h1111); wr_word(17'd1, 16'h2222);
        wr_word(17'd2, 16'h3333); wr_word(17'd4, 16'h5555);
        chk("t2_done_pre", 32'(loading_done), 0);
        pulse_cnt = 0;
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t2_done", 32'(loading_done), 1);
        chk("t2_rest", 32'(rtc_restored), 0);
        tick(6);
        chk("t2_pulses", 32'(pulse_cnt), 0);

        // Out-of-range indices must not complete the footer
        download();
        wr_word(17'd7, 16'hDEAD); wr_word(17'h000FF, 16'hBEEF); wr_word(17'h0000C, 16'hCAFE);
        for (int i = 0; i < 4; i++) wr_word(17'(i), 16'h0100 + 16'(i));
        pulse_cnt = 0;
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t3a_done", 32'(loading_done), 1);
        chk("t3a_rest", 32'(rtc_restored), 0);
        tick(5);
        chk("t3a_pulses", 32'(pulse_cnt), 0);

        // Full footer without an RTC mapper
        download();
        full_footer(16'h0707);
        RTC_valid = 1'b0;
        pulse_cnt = 0;
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t3b_done", 32'(loading_done), 1);
        chk("t3b_rest", 32'(rtc_restored), 0);
        tick(5);
        chk("t3b_pulses", 32'(pulse_cnt), 0);
        RTC_valid = 1'b1;

        // Rewrite of word 2; word 4 arrives on the release cycle
        download();
        wr_word(17'd0, 16'h1111); wr_word(17'd1, 16'h2222); wr_word(17'd2, 16'hAAAA);
        wr_word(17'd3, 16'h4444); wr_word(17'd2, 16'hBBBB);
        bus.wr_in = 1'b1; bus.addr_in = 17'd4; bus.data_in = 16'h5555;
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        #1 bus.wr_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            if (k == 4) begin
                chk("t4_addr2", 32'(bus.addr_out), 2);
                chk("t4_data2", 32'(bus.data_out), 32'h0000_BBBB);
            end
            if (k == 8) chk("t4_data4", 32'(bus.data_out), 32'h0000_5555);
            if (k == 9) chk("t4_rest", 32'(rtc_restored), 1);
        end

        // Download aborts replay at R4, then a fresh footer replays
        download();
        full_footer(16'h1111);
        pulse_cnt = 0;
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        tick(5);
        cart_download = 1'b1;
        external_reset_s = 1'b1;
        tick();
        chk("t5_wr_abort", 32'(bus.wr_out), 0);
        chk("t5_done_abort", 32'(loading_done), 0);
        cart_download = 1'b0;
        tick(4);
        chk("t5_pulses_abort", 32'(pulse_cnt), 3);
        full_footer(16'h0101);
        pulse_cnt = 0;
        external_reset_s = 1'b0;
        tick(12);
        chk("t5_pulses_new", 32'(pulse_cnt), 5);
        chk("t5_done_new", 32'(loading_done), 1);
        chk("t5_rest_new", 32'(rtc_restored), 1);

        // Asynchronous reset at R3
        download();
        full_footer(16'h2222);
        external_reset_s = 1'b0;
        @(posedge clk_sys);
        tick(4);
        pulse_cnt = 0;
        #2 reset = 1'b1;
        #1;
        chk("t6_wr", 32'(bus.wr_out), 0);
        chk("t6_addr", 32'(bus.addr_out), 0);
        chk("t6_data", 32'(bus.data_out), 0);
        chk("t6_done", 32'(loading_done), 0);
        chk("t6_rest", 32'(rtc_restored), 0);
        tick();
        reset = 1'b0;
        external_reset_s = 1'b1;
        tick();
        external_reset_s = 1'b0;
        tick(6);
        chk("t6_done_after", 32'(loading_done), 0);
        chk("t6_pulses", 32'(pulse_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rtc_restore_sequencer.md
# rtc_restore_sequencer

Captures the 5-word RTC footer that the save loader writes beyond the cart-RAM image. Holds the footer until the host releases the core from reset after a cartridge download, then replays it to the cartridge RTC as a paced burst of word writes. Reports completion on `loading_done`. Sits between the save handler's RTC write path (`rtc_wr_in`/`loader_addr`/`bk_data_int`) and the shared backup bus, where `wr_out` selects `bk_rtc_wr` and drives `bk_addr`/`bk_data`.

## Interface
Parameters:
- `REPLAY_GAP`, default 1: idle cycles between consecutive replay writes (0–7).
- `FOOTER_WORDS`, default 5: footer word count; word 0–1 are timestamp, word 2–4 are saved time.

Ports:
- `clk_sys`  in  1  core clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `external_reset_s`  in  1  host reset request, already synchronised to `clk_sys`; high holds the core in reset.
- `cart_download`  in  1  high while ROM download is in progress.
- `RTC_valid`  in  1  cart mapper has an RTC; sampled at replay decision.
- `addr_in`  in  17  footer word address from the save loader; word index = `addr_in[7:0]`.
- `data_in`  in  16  footer word data.
- `wr_in`  in  1  one-cycle write strobe for the footer region.
- `addr_out`  out  17  replay word address = word index, zero-extended.
- `data_out`  out  16  replay word data; 0 when `wr_out` is low.
- `wr_out`  out  1  one-cycle replay write strobe to the RTC.
- `loading_done`  out  1  high once the replay decision is complete.
- `rtc_restored`  out  1  high if a full footer was replayed since the last download.

## Operation
- Storage:
  - Buffer of FOOTER_WORDS × 16 bits.
  - 5-bit `valid_mask`, one bit per word.
  - 3-bit replay index.
- States: IDLE, LOAD, ARMED, REPLAY, DONE. Reset enters IDLE.
- Any state with `cart_download`=1 goes to LOAD, with this priority over everything else:
  - clears `valid_mask`, `loading_done` and `rtc_restored`;
  - aborts a replay in progress; no further `wr_out` pulses.
- IDLE: waits; accepts captures.
- LOAD: waits for `cart_download`=0, then goes to ARMED; accepts captures.
- Capture (IDLE, LOAD and ARMED only), when `wr_in`=1:
  - index < FOOTER_WORDS: write `data_in` to buffer[index] and set `valid_mask[index]`.
  - index ≥ FOOTER_WORDS: ignore.
  - Rewriting a word overwrites it; the last write wins.
- ARMED: when `external_reset_s`=0:
  - `valid_mask`=all-ones and `RTC_valid`=1: go to REPLAY with index 0.
  - otherwise: go to DONE with `rtc_restored`=0.
- ARMED with `wr_in` and release in the same cycle: the word is captured, and it is included in the decision.
- REPLAY:
  - Emits `wr_out` for index 0..FOOTER_WORDS−1 in order, with `addr_out`=index and `data_out`=buffer[index].
  - Inserts REPLAY_GAP idle cycles between writes.
  - After the last write, goes to DONE and sets `rtc_restored`=1.
  - `wr_in` is ignored.
- REPLAY with `external_reset_s` reasserted: the replay continues; the RTC is not under core reset.
- DONE: `loading_done`=1; holds until reset or a new `cart_download`; `wr_in` is ignored.
- A save reload without a new ROM download requires a new `cart_download` pulse; the block does not re-arm otherwise.

## Timing
- All outputs are registered.
- Reset values: `addr_out`=0, `data_out`=0, `wr_out`=0, `loading_done`=0, `rtc_restored`=0, state IDLE, `valid_mask`=0.
- Capture latency: the word is stored on the `wr_in` edge and is visible to the ARMED decision in the same cycle.
- Replay: let cycle R0 be the first cycle in REPLAY, with G=REPLAY_GAP.
  - `wr_out`=1 at R0, R(1+G), R2(1+G), … and is 1 cycle wide.
  - Default timing: pulses at R0, R2, R4, R6, R8.
  - DONE, `loading_done`=1 and `rtc_restored`=1 from the cycle after the last pulse (R9 by default).
- ARMED→DONE without replay: `loading_done`=1 on the cycle after `external_reset_s` is sampled low.
- `cart_download` rising: `loading_done` and `wr_out` are 0 from the next cycle.
- Asynchronous `reset` mid-replay: all outputs go to 0 immediately; there is no partial recovery.

## Test plan
- Download pulse → 5 footer writes (idx 0..4: 0x1111, 0x2222, 0x3333, 0x4444, 0x5555) → `RTC_valid`=1, release `external_reset_s` → `wr_out` at R0/2/4/6/8 with `addr_out` 0..4 and matching data; `loading_done`=`rtc_restored`=1 at R9.
- Only 4 words written (idx 3 missing) → release → no `wr_out`; `loading_done`=1 one cycle after release; `rtc_restored`=0.
- Full footer with `RTC_valid`=0 → release → no writes, `loading_done`=1. Writes to idx 7 and 0xFF are ignored and do not set the mask.
- Idx 2 written twice (0xAAAA, then 0xBBBB) → replay emits 0xBBBB at `addr_out`=2.
- `cart_download` raised during the R4 pulse → no further `wr_out`; `loading_done`=0 next cycle; a new footer plus release replays correctly.
- `reset` asserted at R3 → all outputs 0 immediately; state IDLE; release without a download produces no writes and `loading_done` stays 0.
